// File: rtl/core_axi_rd_arb.sv
// core_axi_rd_arb: two-master (M0 fetch, M1 data load) to one-slave AXI4-Lite read arbiter.
// One read in flight at a time; AR is routed to the slave, R is routed back to the winner.
// Optional feature macro: ARB_RR_EN selects round-robin arbitration. When it is undefined,
// M1 has fixed priority over M0.
module core_axi_rd_arb #(
    parameter int unsigned AXI_AWIDTH = 4,
    parameter int unsigned AXI_DWIDTH = 32
) (
    input  logic                  CLK,
    input  logic                  RST,
    // M0: instruction fetch
    input  logic [AXI_AWIDTH-1:0] M0_ARADDR,
    input  logic                  M0_ARVALID,
    output logic                  M0_ARREADY,
    output logic [AXI_DWIDTH-1:0] M0_RDATA,
    output logic [1:0]            M0_RRESP,
    output logic                  M0_RVALID,
    input  logic                  M0_RREADY,
    // M1: data load
    input  logic [AXI_AWIDTH-1:0] M1_ARADDR,
    input  logic                  M1_ARVALID,
    output logic                  M1_ARREADY,
    output logic [AXI_DWIDTH-1:0] M1_RDATA,
    output logic [1:0]            M1_RRESP,
    output logic                  M1_RVALID,
    input  logic                  M1_RREADY,
    // Slave
    output logic [AXI_AWIDTH-1:0] S_ARADDR,
    output logic                  S_ARVALID,
    input  logic                  S_ARREADY,
    input  logic [AXI_DWIDTH-1:0] S_RDATA,
    input  logic [1:0]            S_RRESP,
    input  logic                  S_RVALID,
    output logic                  S_RREADY
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ADDR = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;

    localparam logic GNT_M0 = 1'b0;
    localparam logic GNT_M1 = 1'b1;

    logic [1:0] state_q, state_d;
    logic       grant_q, grant_d;
    logic       pick;
    logic       ar_hs;
    logic       r_hs;

    assign ar_hs = S_ARVALID && S_ARREADY;
    assign r_hs  = S_RVALID && S_RREADY;

`ifdef ARB_RR_EN
    logic last_q, last_d;

    // Winner selection: on contention serve whoever was not served last
    always_comb begin
        if (M0_ARVALID && M1_ARVALID) begin
            pick = ~last_q;
        end else begin
            pick = M1_ARVALID ? GNT_M1 : GNT_M0;
        end
    end

    // Last-served tracks the owner of each completed R handshake
    always_comb begin
        last_d = last_q;
        if (state_q == ST_DATA && r_hs) begin
            last_d = grant_q;
        end
    end

    // Last-served register
    always_ff @(posedge CLK) begin
        if (RST) begin
            last_q <= GNT_M0;
        end else begin
            last_q <= last_d;
        end
    end
`else
    // Winner selection: the data path always wins so the memory stage never stalls on fetch
    always_comb begin
        pick = M1_ARVALID ? GNT_M1 : GNT_M0;
    end
`endif

    // Next-state and grant: grant may only change while idle
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        case (state_q)
            ST_IDLE: begin
                if (M0_ARVALID || M1_ARVALID) begin
                    grant_d = pick;
                    state_d = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (ar_hs) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (r_hs) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and grant registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            grant_q <= GNT_M1;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
        end
    end

    // Channel routing: AR only in ADDR, R only in DATA, everything else held at zero
    always_comb begin
        S_ARADDR   = '0;
        S_ARVALID  = 1'b0;
        S_RREADY   = 1'b0;
        M0_ARREADY = 1'b0;
        M1_ARREADY = 1'b0;
        M0_RDATA   = '0;
        M0_RRESP   = 2'b00;
        M0_RVALID  = 1'b0;
        M1_RDATA   = '0;
        M1_RRESP   = 2'b00;
        M1_RVALID  = 1'b0;
        if (state_q == ST_ADDR) begin
            if (grant_q == GNT_M1) begin
                S_ARADDR   = M1_ARADDR;
                S_ARVALID  = M1_ARVALID;
                M1_ARREADY = S_ARREADY;
            end else begin
                S_ARADDR   = M0_ARADDR;
                S_ARVALID  = M0_ARVALID;
                M0_ARREADY = S_ARREADY;
            end
        end else if (state_q == ST_DATA) begin
            if (grant_q == GNT_M1) begin
                M1_RDATA  = S_RDATA;
                M1_RRESP  = S_RRESP;
                M1_RVALID = S_RVALID;
                S_RREADY  = M1_RREADY;
            end else begin
                M0_RDATA  = S_RDATA;
                M0_RRESP  = S_RRESP;
                M0_RVALID = S_RVALID;
                S_RREADY  = M0_RREADY;
            end
        end
    end

endmodule

// File: tb/tb_core_axi_rd_arb.sv
// Bench for core_axi_rd_arb: vector table, directed corner sequences, then random traffic
// checked against a transaction-level arbitration/scoreboard model.
module tb_core_axi_rd_arb;

    localparam int AW = 4;
    localparam int DW = 32;

    logic          CLK = 1'b0;
    logic          RST;
    logic [AW-1:0] M0_ARADDR, M1_ARADDR, S_ARADDR;
    logic          M0_ARVALID, M0_ARREADY, M0_RVALID, M0_RREADY;
    logic          M1_ARVALID, M1_ARREADY, M1_RVALID, M1_RREADY;
    logic [DW-1:0] M0_RDATA, M1_RDATA, S_RDATA;
    logic [1:0]    M0_RRESP, M1_RRESP, S_RRESP;
    logic          S_ARVALID, S_ARREADY, S_RVALID, S_RREADY;

    core_axi_rd_arb #(.AXI_AWIDTH(AW), .AXI_DWIDTH(DW)) dut (
        .CLK(CLK), .RST(RST),
        .M0_ARADDR(M0_ARADDR), .M0_ARVALID(M0_ARVALID), .M0_ARREADY(M0_ARREADY),
        .M0_RDATA(M0_RDATA), .M0_RRESP(M0_RRESP), .M0_RVALID(M0_RVALID), .M0_RREADY(M0_RREADY),
        .M1_ARADDR(M1_ARADDR), .M1_ARVALID(M1_ARVALID), .M1_ARREADY(M1_ARREADY),
        .M1_RDATA(M1_RDATA), .M1_RRESP(M1_RRESP), .M1_RVALID(M1_RVALID), .M1_RREADY(M1_RREADY),
        .S_ARADDR(S_ARADDR), .S_ARVALID(S_ARVALID), .S_ARREADY(S_ARREADY),
        .S_RDATA(S_RDATA), .S_RRESP(S_RRESP), .S_RVALID(S_RVALID), .S_RREADY(S_RREADY)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic          m0v, m1v, sarr, srv, m0rr, m1rr;
        logic          sav;
        logic [AW-1:0] saddr;
        logic          m0arr, m1arr, srr, m0rv, m1rv;
    } vec_t;

    vec_t tbl[13];

    // Random-phase model state
    logic          pend[2];
    logic [AW-1:0] maddr[2];
    logic          busy, last, exp_owner;
    logic          s_busy;
    int            s_dly;
    logic [DW-1:0] s_data;
    logic [1:0]    s_resp;
    int            n_tx;

    int ar_own[4];
    int r_own[4];
    int exp_order[4];
    int n_ar, n_r;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        M0_ARVALID = 1'b0; M0_ARADDR = '0; M0_RREADY = 1'b0;
        M1_ARVALID = 1'b0; M1_ARADDR = '0; M1_RREADY = 1'b0;
        S_ARREADY  = 1'b0; S_RVALID  = 1'b0; S_RDATA = '0; S_RRESP = 2'b00;
    endtask

    task automatic reset_dut();
        RST = 1'b1;
        idle_inputs();
        tick();
        tick();
        RST = 1'b0;
    endtask

    task automatic check_quiet(input string tag);
        chk({tag, ".s_arvalid"}, 32'(S_ARVALID), 0);
        chk({tag, ".s_rready"}, 32'(S_RREADY), 0);
        chk({tag, ".m0_arready"}, 32'(M0_ARREADY), 0);
        chk({tag, ".m1_arready"}, 32'(M1_ARREADY), 0);
        chk({tag, ".m0_rvalid"}, 32'(M0_RVALID), 0);
        chk({tag, ".m1_rvalid"}, 32'(M1_RVALID), 0);
        chk({tag, ".m0_rdata"}, M0_RDATA, 0);
        chk({tag, ".m1_rdata"}, M1_RDATA, 0);
        chk({tag, ".m0_rresp"}, 32'(M0_RRESP), 0);
        chk({tag, ".m1_rresp"}, 32'(M1_RRESP), 0);
    endtask

    // Arbitration rule straight from the description
    function automatic logic winner(input logic p0, input logic p1, input logic last_srv);
`ifdef ARB_RR_EN
        if (p0 && p1) return ~last_srv;
`endif
        return p1;
    endfunction

    initial begin
        // Reset state
        reset_dut();
        #1;
        check_quiet("reset");

        // Vector table: M0 alone, then contention (M1 first), then back-pressure on M0
        tbl[0]  = '{0,0,0,0,0,0, 0,4'h0,0,0,0,0,0};
        tbl[1]  = '{1,0,0,0,0,0, 0,4'h0,0,0,0,0,0};
        tbl[2]  = '{1,0,1,0,0,0, 1,4'h4,1,0,0,0,0};
        tbl[3]  = '{0,0,0,1,1,0, 0,4'h0,0,0,1,1,0};
        tbl[4]  = '{1,1,0,0,0,0, 0,4'h0,0,0,0,0,0};
        tbl[5]  = '{1,1,1,0,0,0, 1,4'h8,0,1,0,0,0};
        tbl[6]  = '{1,0,0,1,1,1, 0,4'h0,0,0,1,0,1};
        tbl[7]  = '{1,0,0,0,0,0, 0,4'h0,0,0,0,0,0};
        tbl[8]  = '{1,0,0,0,0,0, 1,4'h4,0,0,0,0,0};
        tbl[9]  = '{1,0,1,0,0,0, 1,4'h4,1,0,0,0,0};
        tbl[10] = '{0,0,0,1,0,0, 0,4'h0,0,0,0,1,0};
        tbl[11] = '{0,0,0,1,1,0, 0,4'h0,0,0,1,1,0};
        tbl[12] = '{0,0,0,0,0,0, 0,4'h0,0,0,0,0,0};
        tick();
        for (int i = 0; i < 13; i++) begin
            M0_ARVALID = tbl[i].m0v;  M1_ARVALID = tbl[i].m1v;
            M0_ARADDR  = 4'h4;        M1_ARADDR  = 4'h8;
            S_ARREADY  = tbl[i].sarr; S_RVALID   = tbl[i].srv;
            M0_RREADY  = tbl[i].m0rr; M1_RREADY  = tbl[i].m1rr;
            S_RDATA    = 32'hDEADBEEF; S_RRESP   = 2'b00;
            #1;
            chk($sformatf("v%0d.s_arvalid", i), 32'(S_ARVALID), 32'(tbl[i].sav));
            if (tbl[i].sav) chk($sformatf("v%0d.s_araddr", i), 32'(S_ARADDR), 32'(tbl[i].saddr));
            chk($sformatf("v%0d.m0_arready", i), 32'(M0_ARREADY), 32'(tbl[i].m0arr));
            chk($sformatf("v%0d.m1_arready", i), 32'(M1_ARREADY), 32'(tbl[i].m1arr));
            chk($sformatf("v%0d.s_rready", i), 32'(S_RREADY), 32'(tbl[i].srr));
            chk($sformatf("v%0d.m0_rvalid", i), 32'(M0_RVALID), 32'(tbl[i].m0rv));
            chk($sformatf("v%0d.m1_rvalid", i), 32'(M1_RVALID), 32'(tbl[i].m1rv));
            chk($sformatf("v%0d.m0_rdata", i), M0_RDATA, tbl[i].m0rv ? 32'hDEADBEEF : 32'h0);
            chk($sformatf("v%0d.m1_rdata", i), M1_RDATA, tbl[i].m1rv ? 32'hDEADBEEF : 32'h0);
            tick();
        end

        // ARVALID drop in ADDR, S_ARREADY held low 5 cycles, RREADY held low 3 cycles
        reset_dut();
        M0_ARVALID = 1'b1; M0_ARADDR = 4'h4;
        tick();
        M0_ARVALID = 1'b0; S_ARREADY = 1'b1;
        #1;
        chk("drop.s_arvalid", 32'(S_ARVALID), 0);
        chk("drop.m1_arready", 32'(M1_ARREADY), 0);
        tick();
        M0_ARVALID = 1'b1; S_ARREADY = 1'b0;
        #1;
        chk("drop.still_addr", 32'(S_ARVALID), 1);
        for (int c = 0; c < 5; c++) begin
            #1;
            chk($sformatf("stall%0d.s_arvalid", c), 32'(S_ARVALID), 1);
            chk($sformatf("stall%0d.s_araddr", c), 32'(S_ARADDR), 4);
            chk($sformatf("stall%0d.m0_arready", c), 32'(M0_ARREADY), 0);
            tick();
        end
        S_ARREADY = 1'b1;
        #1;
        chk("stall.release", 32'(M0_ARREADY), 1);
        tick();
        M0_ARVALID = 1'b0; S_ARREADY = 1'b0;
        S_RVALID = 1'b1; S_RDATA = 32'hCAFE0001; S_RRESP = 2'b10;
        M0_RREADY = 1'b0; M1_ARVALID = 1'b1; M1_ARADDR = 4'h8;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("rhold%0d.s_rready", c), 32'(S_RREADY), 0);
            chk($sformatf("rhold%0d.m0_rvalid", c), 32'(M0_RVALID), 1);
            chk($sformatf("rhold%0d.m1_arready", c), 32'(M1_ARREADY), 0);
            tick();
        end
        M0_RREADY = 1'b1;
        #1;
        chk("rhold.s_rready", 32'(S_RREADY), 1);
        chk("rhold.m0_rdata", M0_RDATA, 32'hCAFE0001);
        chk("rhold.m0_rresp", 32'(M0_RRESP), 2);
        tick();
        S_RVALID = 1'b0; M0_RREADY = 1'b0; S_ARREADY = 1'b1;
        #1;
        chk("bubble.s_arvalid", 32'(S_ARVALID), 0);
        tick();
        #1;
        chk("next.s_arvalid", 32'(S_ARVALID), 1);
        chk("next.s_araddr", 32'(S_ARADDR), 8);

        // Reset pulsed while M1 sits in DATA with a response pending
        tick();
        M1_ARVALID = 1'b0; S_ARREADY = 1'b0; S_RVALID = 1'b1; M1_RREADY = 1'b0;
        #1;
        chk("rstdata.m1_rvalid", 32'(M1_RVALID), 1);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        idle_inputs();
        #1;
        check_quiet("rstdata");
        M0_ARVALID = 1'b1; M0_ARADDR = 4'h4;
        tick();
        #1;
        chk("fresh.s_arvalid", 32'(S_ARVALID), 1);
        chk("fresh.s_araddr", 32'(S_ARADDR), 4);
        S_ARREADY = 1'b1;
        tick();
        M0_ARVALID = 1'b0; S_ARREADY = 1'b0;
        S_RVALID = 1'b1; S_RDATA = 32'h12345678; M0_RREADY = 1'b1;
        #1;
        chk("fresh.m0_rdata", M0_RDATA, 32'h12345678);
        chk("fresh.s_rready", 32'(S_RREADY), 1);
        tick();

        // Both masters hold ARVALID for four transactions
`ifdef ARB_RR_EN
        exp_order = '{1, 0, 1, 0};
`else
        exp_order = '{1, 1, 1, 1};
`endif
        reset_dut();
        M0_ARVALID = 1'b1; M0_ARADDR = 4'h4; M1_ARVALID = 1'b1; M1_ARADDR = 4'h8;
        S_ARREADY = 1'b1; S_RVALID = 1'b1; M0_RREADY = 1'b1; M1_RREADY = 1'b1;
        S_RDATA = 32'h0BAD0BAD;
        for (int i = 0; i < 4; i++) begin
            ar_own[i] = -1;
            r_own[i] = -1;
        end
        n_ar = 0;
        n_r  = 0;
        for (int c = 0; c < 40 && n_r < 4; c++) begin
            #1;
            if (S_ARVALID && S_ARREADY && n_ar < 4) begin
                ar_own[n_ar] = M1_ARREADY ? 1 : 0;
                n_ar++;
            end
            if (M0_RVALID && M0_RREADY && n_r < 4) begin
                r_own[n_r] = 0;
                n_r++;
            end
            if (M1_RVALID && M1_RREADY && n_r < 4) begin
                r_own[n_r] = 1;
                n_r++;
            end
            tick();
        end
        chk("order.count", 32'(n_r), 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("order%0d.ar_owner", i), 32'(ar_own[i]), 32'(exp_order[i]));
            chk($sformatf("order%0d.r_owner", i), 32'(r_own[i]), 32'(exp_order[i]));
        end

        // Random traffic against the transaction-level model
        reset_dut();
        pend[0] = 1'b0; pend[1] = 1'b0; maddr[0] = '0; maddr[1] = '0;
        busy = 1'b0; last = 1'b0; exp_owner = 1'b0;
        s_busy = 1'b0; s_dly = 0; s_data = '0; s_resp = 2'b00; n_tx = 0;
        for (int c = 0; c < 4000; c++) begin
            for (int k = 0; k < 2; k++) begin
                if (!pend[k] && $urandom_range(0, 2) == 0) begin
                    pend[k] = 1'b1;
                    maddr[k] = AW'($urandom);
                end
            end
            M0_ARVALID = pend[0]; M0_ARADDR = maddr[0];
            M1_ARVALID = pend[1]; M1_ARADDR = maddr[1];
            M0_RREADY = 1'($urandom); M1_RREADY = 1'($urandom);
            S_ARREADY = 1'($urandom);
            if (s_busy && s_dly == 0) begin
                S_RVALID = 1'b1; S_RDATA = s_data; S_RRESP = s_resp;
            end else begin
                S_RVALID = 1'b0; S_RDATA = $urandom; S_RRESP = 2'($urandom);
            end
            #1;
            if (!busy && (pend[0] || pend[1])) begin
                exp_owner = winner(pend[0], pend[1], last);
                busy = 1'b1;
            end
            chk("rand.exclusive", 32'({M0_ARREADY && M1_ARREADY, M0_RVALID && M1_RVALID}), 0);
            if (S_ARVALID && S_ARREADY) begin
                chk("rand.ar_owner", 32'({M1_ARREADY, M0_ARREADY}), exp_owner ? 2 : 1);
                chk("rand.ar_addr", 32'(S_ARADDR), 32'(maddr[exp_owner]));
                s_busy = 1'b1;
                s_dly = $urandom_range(0, 3);
                s_data = $urandom;
                s_resp = 2'($urandom);
            end
            if ((S_RVALID && S_RREADY) || (M0_RVALID && M0_RREADY) || (M1_RVALID && M1_RREADY)) begin
                chk("rand.r_owner", 32'({M1_RVALID && M1_RREADY, M0_RVALID && M0_RREADY}),
                    exp_owner ? 2 : 1);
                chk("rand.r_slave_hs", 32'(S_RVALID && S_RREADY), 1);
                chk("rand.r_data", exp_owner ? M1_RDATA : M0_RDATA, s_data);
                chk("rand.r_resp", 32'(exp_owner ? M1_RRESP : M0_RRESP), 32'(s_resp));
                s_busy = 1'b0;
                busy = 1'b0;
                last = exp_owner;
                n_tx++;
            end
            if (M0_ARVALID && M0_ARREADY) pend[0] = 1'b0;
            if (M1_ARVALID && M1_ARREADY) pend[1] = 1'b0;
            if (s_busy && s_dly > 0 && !(S_ARVALID && S_ARREADY)) s_dly--;
            tick();
        end
        chk("rand.progress", 32'(n_tx >= 100), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
